// File: rtl/pipe_merge_sink_pkg.sv
// Shared defaults and source encodings for the two-pipeline merge sink.
package pipe_merge_sink_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic {
        SRC_P1 = 1'b0,
        SRC_P2 = 1'b1
    } src_e;

endpackage

// File: rtl/pipe_merge_sink_if.sv
// Bundle of the two upstream pipelines, the merged downstream port and status flags.
interface pipe_merge_sink_if #(
    parameter int DATA_W = pipe_merge_sink_pkg::DATA_W_DEF
);
    logic [DATA_W-1:0] in_data_1;
    logic              in_valid_1;
    logic [DATA_W-1:0] in_data_2;
    logic              in_valid_2;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              out_valid;
    logic              stall;
    logic              overflow;

    modport master (
        output in_data_1, in_valid_1, in_data_2, in_valid_2, out_ready,
        input  out_data, out_src, out_valid, stall, overflow
    );

    modport slave (
        input  in_data_1, in_valid_1, in_data_2, in_valid_2, out_ready,
        output out_data, out_src, out_valid, stall, overflow
    );
endinterface

// File: rtl/merge_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// Latency: word pushed at edge t is on head_dat in cycle t+1.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module merge_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head_dat,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    // Storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pipe_merge_sink.sv
// Merges two pipelines through per-source FIFOs with a round-robin, lock-on-stall arbiter.
// Latency: one cycle from input push to out_valid when the FIFO is empty and uncontended.
// Backpressure: registered stall when either FIFO nears full; words beyond capacity are dropped and flagged.
module pipe_merge_sink
    import pipe_merge_sink_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    pipe_merge_sink_if.slave bus
);
    localparam int              CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   STALL_TH = CW'(DEPTH - 1);

    logic [DATA_W-1:0] head_1, head_2;
    logic [CW-1:0]     cnt_1, cnt_2, nxt_1, nxt_2;
    logic              full_1, full_2, empty_1, empty_2;
    logic              push_1, push_2, pop_1, pop_2;
    logic              out_valid, xfer, grant;
    logic              last_grant, lock, lock_grant;

    merge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
        .clk(clk), .reset(reset), .push(bus.in_valid_1), .push_dat(bus.in_data_1),
        .pop(pop_1), .head_dat(head_1), .count(cnt_1), .full(full_1), .empty(empty_1)
    );

    merge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_2 (
        .clk(clk), .reset(reset), .push(bus.in_valid_2), .push_dat(bus.in_data_2),
        .pop(pop_2), .head_dat(head_2), .count(cnt_2), .full(full_2), .empty(empty_2)
    );

    // A held offer keeps its grant so downstream sees stable data until it accepts.
    always_comb begin
        grant = SRC_P1;
        if (lock) begin
            grant = lock_grant;
        end else if (!empty_1 && !empty_2) begin
            grant = ~last_grant;
        end else if (!empty_2) begin
            grant = SRC_P2;
        end
    end

    assign out_valid = !empty_1 || !empty_2;
    assign xfer      = out_valid && bus.out_ready;
    assign pop_1     = xfer && (grant == SRC_P1);
    assign pop_2     = xfer && (grant == SRC_P2);
    assign push_1    = bus.in_valid_1 && (!full_1 || pop_1);
    assign push_2    = bus.in_valid_2 && (!full_2 || pop_2);
    assign nxt_1     = cnt_1 + CW'(push_1) - CW'(pop_1);
    assign nxt_2     = cnt_2 + CW'(push_2) - CW'(pop_2);

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? (grant ? head_2 : head_1) : '0;
    assign bus.out_src   = out_valid ? grant : 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant   <= SRC_P2;
            lock         <= 1'b0;
            lock_grant   <= SRC_P1;
            bus.stall    <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            if (xfer) begin
                last_grant <= grant;
                lock       <= 1'b0;
            end else if (out_valid) begin
                lock       <= 1'b1;
                lock_grant <= grant;
            end
            bus.stall <= (nxt_1 >= STALL_TH) || (nxt_2 >= STALL_TH);
            if ((bus.in_valid_1 && full_1 && !pop_1) || (bus.in_valid_2 && full_2 && !pop_2)) begin
                bus.overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_merge_sink.sv
// Directed-vector bench with an expected-output queue checked by an independent monitor.
module tb_pipe_merge_sink;
    localparam int DW = 32;
    localparam int DP = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipe_merge_sink_if #(.DATA_W(DW)) dif ();

    pipe_merge_sink #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    typedef struct packed {
        logic          src;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Every accepted output word must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && dif.out_valid === 1'b1 && dif.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got data %0d src %0d want no output",
                         dif.out_data, dif.out_src);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", dif.out_data, mon_e.dat);
                check("out_src", {31'd0, dif.out_src}, {31'd0, mon_e.src});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        dif.in_valid_1 = 1'b0;
        dif.in_valid_2 = 1'b0;
        dif.in_data_1  = '0;
        dif.in_data_2  = '0;
    endtask

    task automatic expect_out(input logic s, input logic [DW-1:0] d);
        exp_q.push_back(exp_t'{src: s, dat: d});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_in();
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        dif.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < max) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d words left want 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dif.out_ready = 1'b0;
        idle_in();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, dif.out_valid}, 0);
        check("rst_data", dif.out_data, 0);
        check("rst_src", {31'd0, dif.out_src}, 0);
        check("rst_stall", {31'd0, dif.stall}, 0);
        check("rst_ovf", {31'd0, dif.overflow}, 0);

        // Single word, one-cycle latency.
        step();
        dif.out_ready  = 1'b1;
        dif.in_valid_1 = 1'b1;
        dif.in_data_1  = 5;
        expect_out(1'b0, 5);
        @(negedge clk);
        check("lat_before", {31'd0, dif.out_valid}, 0);
        step();
        idle_in();
        @(negedge clk);
        check("lat_valid", {31'd0, dif.out_valid}, 1);
        step();
        @(negedge clk);
        check("single_empty", {31'd0, dif.out_valid}, 0);

        // Ties alternate starting with pipeline 1.
        step();
        do_reset();
        dif.out_ready  = 1'b1;
        dif.in_valid_1 = 1'b1; dif.in_data_1 = 10;
        dif.in_valid_2 = 1'b1; dif.in_data_2 = 20;
        expect_out(1'b0, 10);
        expect_out(1'b1, 20);
        step();
        idle_in();
        drain(6);
        dif.in_valid_1 = 1'b1; dif.in_data_1 = 11;
        dif.in_valid_2 = 1'b1; dif.in_data_2 = 21;
        expect_out(1'b0, 11);
        expect_out(1'b1, 21);
        step();
        idle_in();
        drain(6);

        // Stall rises on the third buffered word; held output stays stable.
        do_reset();
        dif.out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            dif.in_valid_1 = 1'b1;
            dif.in_data_1  = DW'(i);
            expect_out(1'b0, DW'(i));
            step();
            if (i == 2) check("stall_pre", {31'd0, dif.stall}, 0);
        end
        idle_in();
        @(negedge clk);
        check("stall_hi", {31'd0, dif.stall}, 1);
        check("stall_ovf", {31'd0, dif.overflow}, 0);
        for (int i = 0; i < 2; i++) begin
            check("hold_data", dif.out_data, 1);
            check("hold_valid", {31'd0, dif.out_valid}, 1);
            step();
            @(negedge clk);
        end
        drain(8);
        @(negedge clk);
        check("stall_lo", {31'd0, dif.stall}, 0);
        check("stall_empty", {31'd0, dif.out_valid}, 0);

        // Ignoring stall: fifth word is dropped and overflow sticks.
        step();
        do_reset();
        dif.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            dif.in_valid_1 = 1'b1;
            dif.in_data_1  = DW'(i);
            if (i <= 4) expect_out(1'b0, DW'(i));
            step();
            if (i == 4) check("ovf_pre", {31'd0, dif.overflow}, 0);
        end
        idle_in();
        check("ovf_set", {31'd0, dif.overflow}, 1);
        drain(10);
        @(negedge clk);
        check("ovf_sticky", {31'd0, dif.overflow}, 1);
        check("ovf_empty", {31'd0, dif.out_valid}, 0);

        // Grant lock: last transfer was pipeline 1, so an unlocked tie would pick pipeline 2.
        step();
        dif.out_ready  = 1'b0;
        dif.in_valid_1 = 1'b1; dif.in_data_1 = 7;
        expect_out(1'b0, 7);
        step();
        idle_in();
        dif.in_valid_2 = 1'b1; dif.in_data_2 = 8;
        expect_out(1'b1, 8);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lock_data", dif.out_data, 7);
            check("lock_src", {31'd0, dif.out_src}, 0);
            step();
        end
        drain(6);

        // Mid-operation reset discards buffered words and inputs seen during reset.
        dif.out_ready  = 1'b0;
        dif.in_valid_1 = 1'b1; dif.in_data_1 = 30;
        dif.in_valid_2 = 1'b1; dif.in_data_2 = 40;
        step();
        idle_in();
        step();
        reset          = 1'b1;
        dif.in_valid_1 = 1'b1; dif.in_data_1 = 99;
        step();
        reset = 1'b0;
        idle_in();
        @(negedge clk);
        check("mid_rst_valid", {31'd0, dif.out_valid}, 0);
        check("mid_rst_stall", {31'd0, dif.stall}, 0);
        check("mid_rst_ovf", {31'd0, dif.overflow}, 0);
        dif.out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("mid_rst_quiet", {31'd0, dif.out_valid}, 0);

        check("queue_empty", DW'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_merge_sink.md
PIPE_MERGE_SINK -- requirements
Module: pipe_merge_sink

Interface
REQ-001 Parameter DATA_W, default 32, width of each data word.
REQ-002 Parameter DEPTH, default 4, entries per input FIFO; power of two, minimum 4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data_1  input  DATA_W  data word from pipeline 1.
REQ-006 in_valid_1  input  1  in_data_1 is valid this cycle.
REQ-007 in_data_2  input  DATA_W  data word from pipeline 2.
REQ-008 in_valid_2  input  1  in_data_2 is valid this cycle.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  DATA_W  merged output word.
REQ-011 out_src  output  1  source of out_data: 0 = pipeline 1, 1 = pipeline 2.
REQ-012 out_valid  output  1  out_data/out_src are valid.
REQ-013 stall  output  1  registered global stall request to both pipelines.
REQ-014 overflow  output  1  sticky flag: a word was dropped.

Function
REQ-015 Each input SHALL feed its own DEPTH-entry first-word-fall-through FIFO; a push occurs when in_valid_N is high and the FIFO is not full, or is full and popped in the same cycle.
REQ-016 A word pushed at edge t SHALL be visible on out_data no earlier than cycle t+1 (one-cycle latency, empty FIFO, no contention).
REQ-017 When in_valid_N is high, FIFO N is full and no pop occurs on it, the word SHALL be dropped and overflow set to 1 until reset.
REQ-018 Transfer occurs when out_valid and out_ready are both high; only the granted FIFO pops.
REQ-019 out_valid SHALL be high whenever either FIFO is non-empty.
REQ-020 Arbiter: if only one FIFO is non-empty it is granted; if both are, the FIFO not granted on the last transfer is granted (round-robin); last_grant resets to 1, so pipeline 1 wins the first tie.
REQ-021 While out_valid is high and out_ready low, grant, out_data and out_src SHALL be held stable (grant locked) until the transfer.
REQ-022 last_grant SHALL update only on a transfer.
REQ-023 Per-FIFO count SHALL be unchanged on simultaneous push and pop, +1 on push only, -1 on pop only; pointers wrap modulo DEPTH.
REQ-024 stall SHALL be registered as 1 when either FIFO's next-cycle count is >= DEPTH-1, else 0.
REQ-025 Upstream honours stall combinationally (no new valid in a cycle with stall high); with that contract no word SHALL be dropped.
REQ-026 Per-source ordering SHALL be preserved; no word is duplicated.

Reset
REQ-027 When reset is high at a rising edge: both FIFOs empty, pointers 0, last_grant 1, lock clear, stall 0, overflow 0.
REQ-028 In the cycle after reset, out_valid SHALL be 0; out_data and out_src SHALL be 0 while out_valid is 0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered words; inputs presented during reset are ignored.

Structure
REQ-030 The shared project package SHALL hold DATA_W, DEPTH defaults and the SRC_P1/SRC_P2 encodings.
REQ-031 One sub-module, merge_fifo (FWFT FIFO with count output), SHALL be instantiated twice; arbiter, stall and overflow logic reside in pipe_merge_sink.

Verification
REQ-032 Reset, then in_valid_1=1, in_data_1=5 for one cycle, out_ready=1 -> next cycle out_valid=1, out_data=5, out_src=0; following cycle out_valid=0.
REQ-033 Same cycle push 10 on pipe 1 and 20 on pipe 2, out_ready=1 -> outputs 10 (src 0) then 20 (src 1); a second tie 11/21 -> 11 then 21.
REQ-034 out_ready=0, push 1,2,3 on pipe 1 -> stall=1 after the third push edge; no valid while stall=1; overflow stays 0; release out_ready -> 1,2,3 in order, stall falls.
REQ-035 out_ready=0, force in_valid_1 for 5 cycles ignoring stall (data 1..5) -> word 5 dropped, overflow=1; drain yields 1,2,3,4.
REQ-036 out_ready=0 with word 7 from pipe 1 pending, then push 8 on pipe 2 -> out_data holds 7, src 0 until out_ready=1; then 8, src 1.
REQ-037 Two words buffered, assert reset one cycle -> out_valid=0, stall=0, overflow=0 next cycle; nothing pre-reset emerges.
